// File: rtl/w5500_tx_frame.sv
// w5500_tx_frame: turns one payload-buffer transmit request into the three
// W5500 SPI write frames (TX-buffer payload, Sn_TX_WR update, Sn_CR=SEND).
// Bytes leave on a valid/ready interface toward the SPI byte engine.
// Optional build macro W5500_TX_CLAMP_EN clamps the latched length to TX_BUF_SIZE.
module w5500_tx_frame #(
  parameter int SOCK        = 0,
  parameter int CS_GAP      = 2,
  parameter int TX_BUF_SIZE = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dat_tx_req,
  input  logic [15:0] dat_len,
  output logic        o_dat_tx_rden,
  input  logic [7:0]  dat,
  output logic        o_dat_tx_end,
  output logic        o_spi_cs,
  output logic [7:0]  o_spi_byte,
  output logic        o_spi_vld,
  input  logic        spi_rdy,
  input  logic        i_sock_open,
  output logic        o_busy
);

  localparam logic [4:0]  LP_BSB_REG = 5'(4 * SOCK + 1);
  localparam logic [4:0]  LP_BSB_TX  = 5'(4 * SOCK + 2);
  localparam logic [7:0]  LP_CTRL_D  = {LP_BSB_TX, 1'b1, 2'b00};
  localparam logic [7:0]  LP_CTRL_R  = {LP_BSB_REG, 1'b1, 2'b00};
  localparam logic [15:0] LP_GAP_LD  = 16'(CS_GAP - 1);

  if (CS_GAP < 1 || SOCK < 0 || SOCK > 7 || TX_BUF_SIZE < 1 || TX_BUF_SIZE > 65535) begin : g_param_check
    $error("w5500_tx_frame: illegal parameter value");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_D, S_RD, S_CAP, S_SND, S_GAP1, S_PTR, S_GAP2, S_CMD, S_DONE, S_REL
  } state_t;

  // Payload-frame header: write address (current pointer) then control byte.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] ptr);
    case (idx)
      3'd0:    hdr_byte = ptr[15:8];
      3'd1:    hdr_byte = ptr[7:0];
      default: hdr_byte = LP_CTRL_D;
    endcase
  endfunction

  // Sn_TX_WR (offset 0x0024) write frame carrying the advanced pointer.
  function automatic logic [7:0] ptr_byte(input logic [2:0] idx, input logic [15:0] ptr);
    case (idx)
      3'd0:    ptr_byte = 8'h00;
      3'd1:    ptr_byte = 8'h24;
      3'd2:    ptr_byte = LP_CTRL_R;
      3'd3:    ptr_byte = ptr[15:8];
      default: ptr_byte = ptr[7:0];
    endcase
  endfunction

  // Sn_CR (offset 0x0001) write frame with the SEND command.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h00;
      3'd1:    cmd_byte = 8'h01;
      3'd2:    cmd_byte = LP_CTRL_R;
      default: cmd_byte = 8'h20;
    endcase
  endfunction

  state_t      r_state, w_state_nx;
  logic [2:0]  r_idx, w_idx_nx;
  logic [15:0] r_len, w_len_nx;
  logic [15:0] r_rem, w_rem_nx;
  logic [15:0] r_gap, w_gap_nx;
  logic [15:0] r_wr_ptr;
  logic        r_open_pend;
  logic        r_cs, w_cs_nx;
  logic        r_vld, w_vld_nx;
  logic [7:0]  r_byte, w_byte_nx;
  logic        r_rden, w_rden_nx;
  logic        r_end, w_end_nx;
  logic        r_busy, w_busy_nx;
  logic [15:0] w_len_in;
  logic [15:0] w_new_ptr;
  logic        w_acc;

`ifdef W5500_TX_CLAMP_EN
  localparam logic [15:0] LP_TX_MAX = 16'(TX_BUF_SIZE);
  assign w_len_in = (dat_len > LP_TX_MAX) ? LP_TX_MAX : dat_len;
`else
  assign w_len_in = dat_len;
`endif

  assign w_new_ptr = r_wr_ptr + r_len;
  assign w_acc     = r_vld & spi_rdy;

  assign o_dat_tx_rden = r_rden;
  assign o_dat_tx_end  = r_end;
  assign o_spi_cs      = r_cs;
  assign o_spi_byte    = r_byte;
  assign o_spi_vld     = r_vld;
  assign o_busy        = r_busy;

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_len_nx   = r_len;
    w_rem_nx   = r_rem;
    w_gap_nx   = r_gap;
    w_cs_nx    = r_cs;
    w_vld_nx   = r_vld;
    w_byte_nx  = r_byte;
    w_rden_nx  = 1'b0;
    w_end_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dat_tx_req) begin
          w_len_nx = w_len_in;
          w_rem_nx = w_len_in;
          if (w_len_in == 16'd0) begin
            w_state_nx = S_DONE;
            w_end_nx   = 1'b1;
          end else begin
            w_state_nx = S_HDR_D;
            w_cs_nx    = 1'b1;
            w_vld_nx   = 1'b1;
            w_idx_nx   = 3'd0;
            w_byte_nx  = hdr_byte(3'd0, r_wr_ptr);
          end
        end else begin
          w_cs_nx  = 1'b0;
          w_vld_nx = 1'b0;
        end
      end
      S_HDR_D: begin
        if (w_acc) begin
          if (r_idx == 3'd2) begin
            w_vld_nx   = 1'b0;
            w_rden_nx  = 1'b1;
            w_state_nx = S_RD;
          end else begin
            w_idx_nx  = r_idx + 3'd1;
            w_byte_nx = hdr_byte(r_idx + 3'd1, r_wr_ptr);
          end
        end else begin
          w_vld_nx = 1'b1;
        end
      end
      S_RD: begin
        w_state_nx = S_CAP;
      end
      S_CAP: begin
        w_byte_nx  = dat;
        w_vld_nx   = 1'b1;
        w_state_nx = S_SND;
      end
      S_SND: begin
        if (w_acc) begin
          w_vld_nx = 1'b0;
          w_rem_nx = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_cs_nx    = 1'b0;
            w_gap_nx   = LP_GAP_LD;
            w_state_nx = S_GAP1;
          end else begin
            w_rden_nx  = 1'b1;
            w_state_nx = S_RD;
          end
        end else begin
          w_vld_nx = 1'b1;
        end
      end
      S_GAP1, S_GAP2: begin
        if (r_gap == 16'd0) begin
          w_cs_nx    = 1'b1;
          w_vld_nx   = 1'b1;
          w_idx_nx   = 3'd0;
          w_byte_nx  = 8'h00;
          w_state_nx = (r_state == S_GAP1) ? S_PTR : S_CMD;
        end else begin
          w_gap_nx = r_gap - 16'd1;
        end
      end
      S_PTR: begin
        if (w_acc) begin
          if (r_idx == 3'd4) begin
            w_vld_nx   = 1'b0;
            w_cs_nx    = 1'b0;
            w_gap_nx   = LP_GAP_LD;
            w_state_nx = S_GAP2;
          end else begin
            w_idx_nx  = r_idx + 3'd1;
            w_byte_nx = ptr_byte(r_idx + 3'd1, w_new_ptr);
          end
        end else begin
          w_vld_nx = 1'b1;
        end
      end
      S_CMD: begin
        if (w_acc) begin
          if (r_idx == 3'd3) begin
            w_vld_nx   = 1'b0;
            w_cs_nx    = 1'b0;
            w_end_nx   = 1'b1;
            w_state_nx = S_DONE;
          end else begin
            w_idx_nx  = r_idx + 3'd1;
            w_byte_nx = cmd_byte(r_idx + 3'd1);
          end
        end else begin
          w_vld_nx = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_REL;
      end
      S_REL: begin
        if (!dat_tx_req) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_REL;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cs_nx    = 1'b0;
        w_vld_nx   = 1'b0;
      end
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_len   <= 16'd0;
      r_rem   <= 16'd0;
      r_gap   <= 16'd0;
      r_cs    <= 1'b0;
      r_vld   <= 1'b0;
      r_byte  <= 8'h00;
      r_rden  <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_len   <= w_len_nx;
      r_rem   <= w_rem_nx;
      r_gap   <= w_gap_nx;
      r_cs    <= w_cs_nx;
      r_vld   <= w_vld_nx;
      r_byte  <= w_byte_nx;
      r_rden  <= w_rden_nx;
      r_end   <= w_end_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // TX write pointer: commit on DONE; a socket reopen during a transfer is deferred to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= 16'd0;
      r_open_pend <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_wr_ptr    <= (r_open_pend || i_sock_open) ? 16'd0 : w_new_ptr;
      r_open_pend <= 1'b0;
    end else if (i_sock_open) begin
      if (r_state == S_IDLE || r_state == S_REL) begin
        r_wr_ptr <= 16'd0;
      end else begin
        r_open_pend <= 1'b1;
      end
    end
  end

endmodule
